// File: rtl/mac_pkg.sv
// Shared types and helpers for the windowed multiply-accumulate.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mac_pkg;

    // Default widths; the top module takes its parameter defaults from here.
    localparam int DEF_IN_W   = 10;
    localparam int DEF_COEF_W = 4;
    localparam int DEF_ACC_W  = 16;
    localparam int DEF_PROD_W = DEF_IN_W + DEF_COEF_W;

    // Working width of the adder helper; any ACC_W and product width up to
    // this value are handled by masking at the requested accumulator width.
    localparam int SUM_MAX_W = 32;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Adds acc + prod at acc_w+1 bits. Returns {ovf, sum}, where sum is
    // either clamped to all-ones or wrapped to the low acc_w bits.
    function automatic logic [SUM_MAX_W:0] sat_add(
        input logic [SUM_MAX_W-1:0] acc,
        input logic [SUM_MAX_W-1:0] prod,
        input int                   acc_w,
        input bit                   saturate
    );
        logic [SUM_MAX_W:0] full;
        logic [SUM_MAX_W:0] mask;
        logic [SUM_MAX_W:0] sum;
        logic               ovf;
        full = {1'b0, acc} + {1'b0, prod};
        mask = ({{SUM_MAX_W{1'b0}}, 1'b1} << acc_w) - 1'b1;
        ovf  = (full > mask);
        if (!ovf)
            sum = full;
        else if (saturate)
            sum = mask;
        else
            sum = full & mask;
        return {ovf, sum[SUM_MAX_W-1:0]};
    endfunction

endpackage

// File: rtl/mac_window.sv
// Windowed MAC: sums WIN_LEN accepted in_num*coef products, presents the total.
// Latency: result valid the cycle after the last sample of a window is accepted.
// Backpressure: in_ready drops while a result is held until out_ready takes it.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   clr               synchronous clear of the window in progress / held result
//   in_valid/in_ready sample handshake; in_num and coef captured on accept
//   out_valid/out_ready result handshake; out_sum total, out_ovf overflow seen
module mac_window
    import mac_pkg::*;
#(
    parameter int IN_W     = DEF_IN_W,
    parameter int COEF_W   = DEF_COEF_W,
    parameter int ACC_W    = DEF_ACC_W,
    parameter int WIN_LEN  = 10,
    parameter int SATURATE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_num,
    input  logic [COEF_W-1:0] coef,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf
);

    localparam int PROD_W = IN_W + COEF_W;
    localparam int CNT_W  = $clog2(WIN_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIN_LEN - 1);

    state_t               state;
    logic [ACC_W-1:0]     acc;
    logic [CNT_W-1:0]     cnt;
    logic                 flag;

    logic [PROD_W-1:0]    prod;
    logic [SUM_MAX_W:0]   add_r;
    logic [ACC_W-1:0]     acc_nxt;
    logic                 ovf_nxt;
    logic                 accept;
    logic                 unused_hi;

    assign accept  = in_valid && in_ready;
    assign prod    = PROD_W'(in_num) * PROD_W'(coef);
    assign add_r   = sat_add(SUM_MAX_W'(acc), SUM_MAX_W'(prod), ACC_W, SATURATE != 0);
    assign ovf_nxt = add_r[SUM_MAX_W];
    assign acc_nxt = add_r[ACC_W-1:0];
    // Bits above ACC_W are zero by construction of sat_add.
    assign unused_hi = ^add_r[SUM_MAX_W-1:ACC_W];

    // Once saturated, acc holds all-ones and any further add overflows again
    // (or adds zero), so the clamp persists for the rest of the window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            flag      <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
        end else if (clr) begin
            // Any sample offered this cycle is dropped; out_sum left stale.
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            flag      <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        if (cnt == LAST_CNT) begin
                            out_sum   <= acc_nxt;
                            out_ovf   <= flag | ovf_nxt;
                            acc       <= '0;
                            cnt       <= '0;
                            flag      <= 1'b0;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            state     <= HOLD;
                        end else begin
                            acc  <= acc_nxt;
                            flag <= flag | ovf_nxt;
                            cnt  <= cnt + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_window.sv
module tb_mac_window;

    logic        clk;
    logic        rst_n;
    logic        clr       [3];
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic [9:0]  in_num    [3];
    logic [3:0]  coef      [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic [15:0] out_sum   [3];
    logic        out_ovf   [3];

    int n_chk  = 0;
    int n_pass = 0;

    // Expected {ovf, sum} per instance: 0 = default, 1 = wrapping, 2 = WIN_LEN 1.
    logic [16:0] exp_q [3][$];

    mac_window u_dut (
        .clk(clk), .rst_n(rst_n), .clr(clr[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_num(in_num[0]), .coef(coef[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_sum(out_sum[0]), .out_ovf(out_ovf[0])
    );

    mac_window #(.SATURATE(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .clr(clr[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_num(in_num[1]), .coef(coef[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_sum(out_sum[1]), .out_ovf(out_ovf[1])
    );

    mac_window #(.WIN_LEN(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .clr(clr[2]),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_num(in_num[2]), .coef(coef[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_sum(out_sum[2]), .out_ovf(out_ovf[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Drive point: 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one sample to instance k and return after the edge that accepts it.
    task automatic send(input int k, input int n, input int c);
        int t;
        in_valid[k] = 1'b1;
        in_num[k]   = 10'(n);
        coef[k]     = 4'(c);
        t = 0;
        @(negedge clk);
        while (!in_ready[k] && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready[k]) check("send_timeout", 32'(in_ready[k]), 1);
        tick();
        in_valid[k] = 1'b0;
    endtask

    // Scoreboard monitor: compare every output handshake with the queue head.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst_n && out_valid[k] && out_ready[k]) begin
                if (exp_q[k].size() == 0) begin
                    check($sformatf("unexpected_result_%0d", k), 32'(out_valid[k]), 0);
                end else begin
                    logic [16:0] e;
                    e = exp_q[k].pop_front();
                    check($sformatf("result_%0d", k), {15'd0, out_ovf[k], out_sum[k]}, {15'd0, e});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            clr[k] = 1'b0; in_valid[k] = 1'b0; in_num[k] = '0;
            coef[k] = '0; out_ready[k] = 1'b0;
        end
        repeat (2) @(negedge clk);
        check("rst_in_ready",  32'(in_ready[0]), 0);
        check("rst_out_valid", 32'(out_valid[0]), 0);
        check("rst_out_sum",   32'(out_sum[0]), 0);
        check("rst_out_ovf",   32'(out_ovf[0]), 0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rdy_before_edge", 32'(in_ready[0]), 0);
        @(negedge clk);
        check("rdy_after_edge", 32'(in_ready[0]), 1);
        tick();

        // Basic window with backpressure on the result.
        exp_q[0].push_back({1'b0, 16'd20460});
        for (int i = 0; i < 10; i++) send(0, 1023, 2);
        @(negedge clk);
        check("basic_latency_vld", 32'(out_valid[0]), 1);
        check("basic_hold_rdy",    32'(in_ready[0]), 0);
        // Sample offered during HOLD must wait; it becomes the next window's first.
        in_valid[0] = 1'b1; in_num[0] = 10'd1; coef[0] = 4'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_vld", 32'(out_valid[0]), 1);
            check("hold_sum", 32'(out_sum[0]), 20460);
            check("hold_rdy", 32'(in_ready[0]), 0);
        end
        tick();
        out_ready[0] = 1'b1;
        tick();
        @(negedge clk);
        check("after_hs_vld", 32'(out_valid[0]), 0);
        check("after_hs_rdy", 32'(in_ready[0]), 1);
        // Gapped window of ones; the first sample is accepted at the next edge.
        exp_q[0].push_back({1'b0, 16'd10});
        tick();
        in_valid[0] = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            send(0, 1, 1);
        end
        repeat (3) tick();

        // Saturation held, then cleared while in HOLD.
        out_ready[0] = 1'b0;
        for (int i = 0; i < 10; i++) send(0, 1023, 15);
        @(negedge clk);
        check("sat_sum", 32'(out_sum[0]), 65535);
        check("sat_ovf", 32'(out_ovf[0]), 1);
        tick();
        clr[0] = 1'b1;
        tick();
        clr[0] = 1'b0;
        @(negedge clk);
        check("clr_hold_vld",   32'(out_valid[0]), 0);
        check("clr_hold_ovf",   32'(out_ovf[0]), 0);
        check("clr_hold_stale", 32'(out_sum[0]), 65535);
        check("clr_hold_rdy",   32'(in_ready[0]), 1);
        tick();
        out_ready[0] = 1'b1;

        // Clear mid-window with a sample offered in the same cycle.
        exp_q[0].push_back({1'b0, 16'd10});
        for (int i = 0; i < 4; i++) send(0, 100, 1);
        in_valid[0] = 1'b1; in_num[0] = 10'd100; coef[0] = 4'd1; clr[0] = 1'b1;
        tick();
        clr[0] = 1'b0; in_valid[0] = 1'b0;
        for (int i = 0; i < 10; i++) send(0, 1, 1);
        repeat (3) tick();

        // Wrapping instance.
        out_ready[1] = 1'b1;
        exp_q[1].push_back({1'b1, 16'd22378});
        for (int i = 0; i < 10; i++) send(1, 1023, 15);
        repeat (3) tick();

        // WIN_LEN=1: in_valid held high, one accept every two cycles.
        out_ready[2] = 1'b1;
        exp_q[2].push_back({1'b0, 16'd7});
        exp_q[2].push_back({1'b0, 16'd9});
        exp_q[2].push_back({1'b0, 16'd11});
        in_valid[2] = 1'b1; coef[2] = 4'd1;
        for (int i = 0; i < 3; i++) begin
            in_num[2] = 10'(7 + 2 * i);
            @(negedge clk);
            check("w1_rdy", 32'(in_ready[2]), 1);
            tick();
            @(negedge clk);
            check("w1_vld", 32'(out_valid[2]), 1);
            check("w1_busy", 32'(in_ready[2]), 0);
            tick();
        end
        in_valid[2] = 1'b0;
        @(negedge clk);
        check("w1_one_cycle", 32'(out_valid[2]), 0);
        tick();

        // Reset in the middle of a window.
        for (int i = 0; i < 6; i++) send(0, 5, 3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rdy", 32'(in_ready[0]), 0);
        check("mid_rst_vld", 32'(out_valid[0]), 0);
        check("mid_rst_sum", 32'(out_sum[0]), 0);
        check("mid_rst_ovf", 32'(out_ovf[0]), 0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_rdy_lo", 32'(in_ready[0]), 0);
        @(negedge clk);
        check("mid_rst_rdy_hi", 32'(in_ready[0]), 1);
        tick();
        exp_q[0].push_back({1'b0, 16'd150});
        for (int i = 0; i < 10; i++) send(0, 5, 3);
        repeat (4) tick();

        for (int k = 0; k < 3; k++)
            check($sformatf("drain_%0d", k), 32'(exp_q[k].size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mac_window.md
Name: mac_window

Overview:
Parametrised windowed multiply-accumulate: sums WIN_LEN accepted samples of in_num*coef, then presents the window total on a valid/ready output port.
- Adds a runtime coefficient, an explicit window length, saturation/overflow flagging, synchronous clear, and valid/ready flow control on both sides.
- Sits between a sample source and a downstream consumer in the datapath.

Parameters:
- IN_W, 10, sample width (unsigned)
- COEF_W, 4, coefficient width (unsigned)
- ACC_W, 16, accumulator and result width
- WIN_LEN, 10, accepted samples per window (>=1)
- SATURATE, 1, 1 = clamp on overflow, 0 = wrap modulo 2^ACC_W

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous clear of the window in progress
- in_valid  in  1  sample valid
- in_ready  out  1  block can accept a sample
- in_num  in  IN_W  sample, unsigned
- coef  in  COEF_W  multiplier, sampled with in_num on accept
- out_valid  out  1  window result valid
- out_ready  in  1  consumer accepts result
- out_sum  out  ACC_W  window total
- out_ovf  out  1  overflow occurred in this window

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: in_ready=0, out_valid=0, out_sum=0, out_ovf=0, acc=0, cnt=0, state=ACCUM.
- in_ready is registered. It rises on the first clk edge after rst_n deasserts.
- Accept: in_valid && in_ready on a rising edge.
- Product: in_num*coef, full width IN_W+COEF_W, zero-extended.
- Sum: computed at ACC_W+1 bits. If the carry bit is set, the window's ovf flag sets (sticky within the window).
  - SATURATE=1: acc = 2^ACC_W-1, and stays saturated for the rest of the window.
  - SATURATE=0: acc = low ACC_W bits.
- cnt: width $clog2(WIN_LEN+1). Increments on each accept.
- State ACCUM:
  - in_ready=1 and out_valid=0.
  - An accept with cnt==WIN_LEN-1 loads out_sum=acc+product and out_ovf=flag, clears acc, cnt and flag, and sets in_ready=0 and out_valid=1 at the next edge.
  - Latency: result is valid the cycle after the last sample is accepted.
- State HOLD:
  - out_valid=1; out_sum and out_ovf are stable; in_ready=0.
  - On out_valid && out_ready: next edge out_valid=0, in_ready=1, state=ACCUM.
  - There is no same-cycle overlap of output handshake and input accept.
- Gaps: in_valid low cycles change nothing. Samples need not be contiguous.
- WIN_LEN=1: every accept goes straight to HOLD.
- clr (either state):
  - Next edge: acc=0, cnt=0, flag=0, out_valid=0, out_ovf=0, in_ready=1, state=ACCUM.
  - A sample presented in the same cycle as clr is discarded.
  - A pending HOLD result is dropped; out_sum keeps its stale value but is not valid.
- Reset mid-window or mid-HOLD: all state returns to reset values immediately (asynchronous). No partial result is emitted.
- in_num and coef are don't-care when in_valid is low.
- in_valid has no requirement to be held; the block does not register unaccepted data.

Decomposition:
- Package mac_pkg:
  - state enum typedef {ACCUM, HOLD}.
  - Function sat_add(acc, prod, saturate), returning {ovf, sum}.
  - Width helper constants derived from IN_W, COEF_W and ACC_W.
- No sub-module: the datapath is one multiply, one adder and a counter, so it stays in one module.

Test Plan (default parameters unless stated):
- Basic window: 10 accepts of in_num=1023, coef=2 -> out_valid=1 exactly 1 cycle after the 10th accept; out_sum=20460; out_ovf=0; in_ready=0 while out_valid is held.
- Saturation: 10 accepts of 1023 with coef=15 (153450 > 65535) -> out_sum=65535, out_ovf=1. With SATURATE=0 -> out_sum=153450 mod 65536=22378, out_ovf=1.
- Backpressure and gaps:
  - Valid samples alternate with idle cycles; out_ready held low for 5 cycles after the result.
  - out_sum and out_valid stay stable throughout; in_valid=1 during HOLD is not accepted.
  - The next window starts the cycle after the handshake.
- Clear mid-window: 4 accepts of 100 with coef=1, then clr asserted together with in_valid (that sample is discarded), then 10 accepts of 1 with coef=1 -> out_sum=10, out_ovf=0.
- Reset mid-operation: drop rst_n after 6 accepts -> all outputs read 0 while rst_n is low; in_ready=1 one edge after release; a fresh 10-sample window of 5 with coef=3 -> out_sum=150.
- WIN_LEN=1 and back-to-back: with out_ready held high, accepts of 7, 9, 11 with coef=1 -> three results 7, 9, 11. Each result is valid for one cycle, and an input is accepted every 2 cycles.
